// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end: drives the imem handshake,
// absorbs stalls with a one-entry skid register, and cancels in-flight fetches on redirect.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_BOOT  | one idle cycle after reset, no request
// S_FETCH | request outstanding at imem_addr = pc
// S_HOLD  | stalled with a valid instruction held, no request
// S_HALT  | misaligned redirect seen; frozen bubble until reset
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCsrc,
  input  logic [31:0] branchTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        nop,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic        discard_q, discard_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= RESET_PC;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      discard_q    <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      discard_q    <= discard_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    misaligned_d = misaligned_q;
    discard_d    = discard_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        if (imem_ready && discard_q) begin
          // Late response to a cancelled request: swallow it and keep pc.
          discard_d = 1'b0;
          if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end else if (imem_ready) begin
          // Downstream still owns the current instruction, so park the new one.
          if (stall && valid_q) begin
            skid_v_d     = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end
          pc_d = pc_q + 32'd4;
          if (stall) state_d = S_HOLD;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end

      S_HOLD: begin
        if (!stall) begin
          state_d = S_FETCH;
          if (skid_v_q) begin
            instr_d  = skid_instr_q;
            pc_out_d = skid_pc_q;
            valid_d  = 1'b1;
            skid_v_d = 1'b0;
          end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
      end

      default: ;
    endcase

    if (PCsrc && (state_q != S_HALT)) begin
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      pc_out_d = pc_out_q;
      skid_v_d = 1'b0;
      if (branchTarget[1:0] == 2'b00) begin
        pc_d      = branchTarget;
        state_d   = S_FETCH;
        discard_d = (state_q == S_FETCH) && !imem_ready;
      end else begin
        pc_d         = pc_q;
        misaligned_d = 1'b1;
        discard_d    = 1'b0;
        state_d      = S_HALT;
      end
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign nop         = ~valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table over a small imem model
// that answers addr+1000 after a programmable number of wait cycles.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        PCsrc = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        nop;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  logic        pend_v = 1'b0;
  logic [31:0] pend_a = 32'h0;
  int          pend_cnt = 0;
  int          mem_delay = 0;

  localparam logic [31:0] NOPI = 32'h0000_0013;

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .PCsrc(PCsrc), .branchTarget(branchTarget),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .instr_valid(instr_valid), .nop(nop), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pcsrc;
    logic [31:0] tgt;
    logic        stl;
    int          dly;
    logic        v;
    logic [31:0] pco;
    logic [31:0] ins;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: latches the request address when idle, answers after dly wait cycles.
  task automatic mem_step();
    imem_ready = 1'b0;
    if (!pend_v && imem_req) begin
      pend_v   = 1'b1;
      pend_a   = imem_addr;
      pend_cnt = mem_delay;
    end
    if (pend_v) begin
      if (pend_cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = pend_a + 32'd1000;
        pend_v     = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic step(input logic pcsrc, input logic [31:0] tgt, input logic stl, input int dly);
    @(negedge clock);
    reset        = 1'b0;
    mem_delay    = dly;
    mem_step();
    PCsrc        = pcsrc;
    branchTarget = tgt;
    stall        = stl;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, ".nop"}, {31'b0, nop}, 32'd1);
    chk({tag, ".req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, ".mis"}, {31'b0, misaligned}, 32'd0);
    chk({tag, ".instr"}, instr_out, NOPI);
    chk({tag, ".pc_out"}, pc_out, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          pcsrc tgt     stl dly  v     pc_out  instr     req   addr
    tbl[0]  = '{1'b0, 32'h0,  1'b0, 0, 1'b0, 32'h00, NOPI,     1'b1, 32'h00};
    tbl[1]  = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h00, 32'd1000, 1'b1, 32'h04};
    tbl[2]  = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h04, 32'd1004, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 3, 1'b0, 32'h04, NOPI,     1'b1, 32'h08};
    tbl[4]  = '{1'b0, 32'h0,  1'b0, 0, 1'b0, 32'h04, NOPI,     1'b1, 32'h08};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 0, 1'b0, 32'h04, NOPI,     1'b1, 32'h08};
    tbl[6]  = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h08, 32'd1008, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h0C, 32'd1012, 1'b1, 32'h10};
    tbl[8]  = '{1'b1, 32'h40, 1'b0, 0, 1'b0, 32'h0C, NOPI,     1'b1, 32'h40};
    tbl[9]  = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h40, 32'd1064, 1'b1, 32'h44};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 32'h40, 32'd1064, 1'b0, 32'h48};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 32'h40, 32'd1064, 1'b0, 32'h48};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 32'h40, 32'd1064, 1'b0, 32'h48};
    tbl[13] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 32'h40, 32'd1064, 1'b0, 32'h48};
    tbl[14] = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h44, 32'd1068, 1'b1, 32'h48};
    tbl[15] = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h48, 32'd1072, 1'b1, 32'h4C};

    repeat (2) @(posedge clock);
    #1;
    chk_reset_state("reset");

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].pcsrc, tbl[i].tgt, tbl[i].stl, tbl[i].dly);
      chk($sformatf("v%0d.valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].v});
      chk($sformatf("v%0d.nop", i), {31'b0, nop}, {31'b0, ~tbl[i].v});
      chk($sformatf("v%0d.pc_out", i), pc_out, tbl[i].pco);
      chk($sformatf("v%0d.instr", i), instr_out, tbl[i].ins);
      chk($sformatf("v%0d.req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d.addr", i), imem_addr, tbl[i].addr);
    end

    // Redirect during an outstanding slow fetch: the stale 0x20 response must be dropped.
    step(1'b1, 32'h20, 1'b0, 0);
    chk("disc0.addr", imem_addr, 32'h20);
    step(1'b0, 32'h0, 1'b0, 2);
    chk("disc1.valid", {31'b0, instr_valid}, 32'd0);
    step(1'b1, 32'h80, 1'b0, 0);
    chk("disc2.addr", imem_addr, 32'h80);
    chk("disc2.valid", {31'b0, instr_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 0);
    chk("disc3.valid", {31'b0, instr_valid}, 32'd0);
    chk("disc3.instr", instr_out, NOPI);
    chk("disc3.addr", imem_addr, 32'h80);
    step(1'b0, 32'h0, 1'b0, 0);
    chk("disc4.valid", {31'b0, instr_valid}, 32'd1);
    chk("disc4.pc_out", pc_out, 32'h80);
    chk("disc4.instr", instr_out, 32'd1128);
    chk("disc4.addr", imem_addr, 32'h84);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 0);
    chk("wrap0.addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b0, 0);
    chk("wrap1.pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap1.instr", instr_out, 32'h0000_03E4);
    chk("wrap1.addr", imem_addr, 32'h0);

    // Misaligned redirect halts until reset; later redirects are ignored.
    step(1'b1, 32'h42, 1'b0, 0);
    chk("mis0.mis", {31'b0, misaligned}, 32'd1);
    chk("mis0.nop", {31'b0, nop}, 32'd1);
    chk("mis0.req", {31'b0, imem_req}, 32'd0);
    chk("mis0.instr", instr_out, NOPI);
    chk("mis0.addr", imem_addr, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(k == 2, 32'h100, k[0], 0);
      chk($sformatf("mis%0d.req", k + 1), {31'b0, imem_req}, 32'd0);
      chk($sformatf("mis%0d.nop", k + 1), {31'b0, nop}, 32'd1);
      chk($sformatf("mis%0d.mis", k + 1), {31'b0, misaligned}, 32'd1);
    end

    @(negedge clock);
    reset      = 1'b1;
    PCsrc      = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    pend_v     = 1'b0;
    @(posedge clock);
    #1;
    chk_reset_state("rst2");
    chk("rst2.addr", imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b0, 0);
    chk("boot2.req", {31'b0, imem_req}, 32'd1);
    chk("boot2.addr", imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b0, 0);
    chk("run2.valid", {31'b0, instr_valid}, 32'd1);
    chk("run2.pc_out", pc_out, 32'h0);
    chk("run2.instr", instr_out, 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
